// File: rtl/ssram_pkg.sv
// ssram_pkg: shared types and constants for the SSRAM arbiter
// Contents: port-ID enum, default tracking depth, idle data pattern.
package ssram_pkg;
  localparam int ID_W = 1;
  localparam int C_FIFO_DEPTHX_DEF = 2;
  localparam logic [31:0] SSRAM_IDLE_DATA = 32'hbaadf00d;
  typedef enum logic [ID_W-1:0] {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
endpackage

// File: rtl/ssram_arb_tagfifo.sv
// ssram_arb_tagfifo: tracks the port ID of every outstanding read, in issue order
// Ports: clk_i, resetb_i (async active-low), push/din (enqueue ID), pop (dequeue head),
//        full, empty, head (ID of oldest outstanding read).
import ssram_pkg::*;
module ssram_arb_tagfifo #(
  parameter int DX = C_FIFO_DEPTHX_DEF
) (
  input  logic  clk_i,
  input  logic  resetb_i,
  input  logic  push,
  input  logic  pop,
  input  port_e din,
  output logic  full,
  output logic  empty,
  output port_e head
);
  port_e mem [2**DX];
  logic [DX-1:0] wr_ptr, rd_ptr;
  logic [DX:0] cnt;
  // occupancy never exceeds 2**DX, so the top bit alone flags full
  assign full = cnt[DX];
  assign empty = cnt == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{DX{1'b0}}, push} - {{DX{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/ssram_arb.sv
// ssram_arb: two-master (fetch / load-store) arbiter onto one pipelined SSRAM target
// Ports: clk_i, resetb_i (async active-low), clk_en_i; m0_*/m1_* request+response
//        channels per master; s_* request+response channel to target; err_o sticky
//        response-without-read flag.
// Option: define SSRAM_ARB_RR_EN for round-robin arbitration; default is fixed port-0 priority.
import ssram_pkg::*;
module ssram_arb #(
  parameter int C_FIFO_DEPTHX = C_FIFO_DEPTHX_DEF
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  output logic        m0_treqready_o,
  input  logic        m0_treqvalid_i,
  input  logic        m0_treqdvalid_i,
  input  logic [31:0] m0_treqaddr_i,
  input  logic [31:0] m0_treqdata_i,
  input  logic        m0_trspready_i,
  output logic        m0_trspvalid_o,
  output logic [31:0] m0_trspdata_o,
  output logic        m1_treqready_o,
  input  logic        m1_treqvalid_i,
  input  logic        m1_treqdvalid_i,
  input  logic [31:0] m1_treqaddr_i,
  input  logic [31:0] m1_treqdata_i,
  input  logic        m1_trspready_i,
  output logic        m1_trspvalid_o,
  output logic [31:0] m1_trspdata_o,
  input  logic        s_treqready_i,
  output logic        s_treqvalid_o,
  output logic        s_treqdvalid_o,
  output logic [31:0] s_treqaddr_o,
  output logic [31:0] s_treqdata_o,
  output logic        s_trspready_o,
  input  logic        s_trspvalid_i,
  input  logic [31:0] s_trspdata_i,
  output logic        err_o
);
  logic elig0, elig1, gnt0, gnt1, full, empty, push, pop;
  port_e head;
  // writes need no tracking slot, so they stay eligible while the FIFO is full
  assign elig0 = m0_treqvalid_i & (m0_treqdvalid_i | ~full);
  assign elig1 = m1_treqvalid_i & (m1_treqdvalid_i | ~full);
`ifdef SSRAM_ARB_RR_EN
  port_e last;
  assign gnt1 = elig1 & (~elig0 | last == PORT0);
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) last <= PORT1;
    else if (m0_treqready_o | m1_treqready_o) last <= m1_treqready_o ? PORT1 : PORT0;
  end
`else
  assign gnt1 = elig1 & ~elig0;
`endif
  assign gnt0 = elig0 & ~gnt1;
  assign s_treqvalid_o = elig0 | elig1;
  assign s_treqdvalid_o = gnt0 ? m0_treqdvalid_i : gnt1 & m1_treqdvalid_i;
  assign s_treqaddr_o = gnt0 ? m0_treqaddr_i : gnt1 ? m1_treqaddr_i : '0;
  assign s_treqdata_o = gnt0 ? m0_treqdata_i : gnt1 ? m1_treqdata_i : '0;
  assign m0_treqready_o = gnt0 & s_treqready_i & clk_en_i;
  assign m1_treqready_o = gnt1 & s_treqready_i & clk_en_i;
  assign push = (m0_treqready_o | m1_treqready_o) & ~s_treqdvalid_o;
  assign m0_trspvalid_o = s_trspvalid_i & ~empty & head == PORT0;
  assign m1_trspvalid_o = s_trspvalid_i & ~empty & head == PORT1;
  assign m0_trspdata_o = s_trspdata_i;
  assign m1_trspdata_o = s_trspdata_i;
  assign s_trspready_o = empty | (head == PORT1 ? m1_trspready_i : m0_trspready_i);
  assign pop = s_trspvalid_i & s_trspready_o & ~empty & clk_en_i;
  ssram_arb_tagfifo #(.DX(C_FIFO_DEPTHX)) u_tagfifo (
    .clk_i(clk_i),
    .resetb_i(resetb_i),
    .push(push),
    .pop(pop),
    .din(gnt1 ? PORT1 : PORT0),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) err_o <= 1'b0;
    else if (s_trspvalid_i & empty & clk_en_i) err_o <= 1'b1;
  end
endmodule

// File: tb/tb_ssram_arb.sv
// tb_ssram_arb: directed vector table plus corner-case sequences for ssram_arb
module tb_ssram_arb;
  logic clk_i = 1'b0, resetb_i = 1'b0, clk_en_i;
  logic m0_treqready_o, m0_treqvalid_i, m0_treqdvalid_i, m0_trspready_i, m0_trspvalid_o;
  logic [31:0] m0_treqaddr_i, m0_treqdata_i, m0_trspdata_o;
  logic m1_treqready_o, m1_treqvalid_i, m1_treqdvalid_i, m1_trspready_i, m1_trspvalid_o;
  logic [31:0] m1_treqaddr_i, m1_treqdata_i, m1_trspdata_o;
  logic s_treqready_i, s_treqvalid_o, s_treqdvalid_o, s_trspready_o, s_trspvalid_i, err_o;
  logic [31:0] s_treqaddr_o, s_treqdata_o, s_trspdata_i;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  ssram_arb dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .m0_treqready_o(m0_treqready_o), .m0_treqvalid_i(m0_treqvalid_i), .m0_treqdvalid_i(m0_treqdvalid_i),
    .m0_treqaddr_i(m0_treqaddr_i), .m0_treqdata_i(m0_treqdata_i), .m0_trspready_i(m0_trspready_i),
    .m0_trspvalid_o(m0_trspvalid_o), .m0_trspdata_o(m0_trspdata_o),
    .m1_treqready_o(m1_treqready_o), .m1_treqvalid_i(m1_treqvalid_i), .m1_treqdvalid_i(m1_treqdvalid_i),
    .m1_treqaddr_i(m1_treqaddr_i), .m1_treqdata_i(m1_treqdata_i), .m1_trspready_i(m1_trspready_i),
    .m1_trspvalid_o(m1_trspvalid_o), .m1_trspdata_o(m1_trspdata_o),
    .s_treqready_i(s_treqready_i), .s_treqvalid_o(s_treqvalid_o), .s_treqdvalid_o(s_treqdvalid_o),
    .s_treqaddr_o(s_treqaddr_o), .s_treqdata_o(s_treqdata_o), .s_trspready_o(s_trspready_o),
    .s_trspvalid_i(s_trspvalid_i), .s_trspdata_i(s_trspdata_i), .err_o(err_o)
  );
  typedef struct {
    logic ce, v0, d0; logic [31:0] a0; logic r0;
    logic v1, d1; logic [31:0] a1; logic r1;
    logic sready, svalid; logic [31:0] sdata;
    logic rdy0, rdy1, sv, sdv; logic [31:0] saddr;
    logic rv0, rv1, srr, err;
  } vec_t;
  vec_t tbl [14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic idle();
    clk_en_i = 1'b1;
    m0_treqvalid_i = 1'b0; m0_treqdvalid_i = 1'b0; m0_treqaddr_i = '0; m0_treqdata_i = '0; m0_trspready_i = 1'b0;
    m1_treqvalid_i = 1'b0; m1_treqdvalid_i = 1'b0; m1_treqaddr_i = '0; m1_treqdata_i = '0; m1_trspready_i = 1'b0;
    s_treqready_i = 1'b0; s_trspvalid_i = 1'b0; s_trspdata_i = '0;
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    idle();
    resetb_i = 1'b0;
    #1 chk("rst_err", err_o, 0);
    chk("rst_srr", s_trspready_o, 1);
    chk("rst_sv", s_treqvalid_o, 0);
    @(negedge clk_i);
    resetb_i = 1'b1;
  endtask
  logic exp_id [4];
  initial begin
    idle();
    //           ce    v0    d0    a0             r0    v1    d1    a1             r1    srdy  svld  sdata            rdy0  rdy1  sv    sdv   saddr          rv0   rv1   srr   err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h100,       1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h100,       1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h100,       1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h100,       1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h11223344,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h200,       1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h200,       1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'ha5a5a5a5,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'ha5a5a5a5,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h80000000,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h80000000,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h80000000,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h300,       1'b0, 1'b1, 1'b0, 32'h400,       1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h300,       1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h55,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h66,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      clk_en_i = tbl[i].ce;
      m0_treqvalid_i = tbl[i].v0; m0_treqdvalid_i = tbl[i].d0; m0_treqaddr_i = tbl[i].a0;
      m0_treqdata_i = ~tbl[i].a0; m0_trspready_i = tbl[i].r0;
      m1_treqvalid_i = tbl[i].v1; m1_treqdvalid_i = tbl[i].d1; m1_treqaddr_i = tbl[i].a1;
      m1_treqdata_i = ~tbl[i].a1; m1_trspready_i = tbl[i].r1;
      s_treqready_i = tbl[i].sready; s_trspvalid_i = tbl[i].svalid; s_trspdata_i = tbl[i].sdata;
      #2;
      chk($sformatf("v%0d_rdy0", i), m0_treqready_o, tbl[i].rdy0);
      chk($sformatf("v%0d_rdy1", i), m1_treqready_o, tbl[i].rdy1);
      chk($sformatf("v%0d_sv", i), s_treqvalid_o, tbl[i].sv);
      chk($sformatf("v%0d_sdv", i), s_treqdvalid_o, tbl[i].sdv);
      chk($sformatf("v%0d_saddr", i), s_treqaddr_o, tbl[i].saddr);
      chk($sformatf("v%0d_sdata", i), s_treqdata_o, tbl[i].sv ? ~tbl[i].saddr : 32'h0);
      chk($sformatf("v%0d_rv0", i), m0_trspvalid_o, tbl[i].rv0);
      chk($sformatf("v%0d_rv1", i), m1_trspvalid_o, tbl[i].rv1);
      chk($sformatf("v%0d_rd0", i), m0_trspdata_o, tbl[i].sdata);
      chk($sformatf("v%0d_rd1", i), m1_trspdata_o, tbl[i].sdata);
      chk($sformatf("v%0d_srr", i), s_trspready_o, tbl[i].srr);
      chk($sformatf("v%0d_err", i), err_o, tbl[i].err);
    end
    // tracking FIFO fills at four reads; a same-cycle pop does not free a slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle();
      m0_treqvalid_i = 1'b1; m0_treqaddr_i = 32'h1000 + 32'(i); s_treqready_i = 1'b1;
      #2 chk($sformatf("fill%0d_rdy0", i), m0_treqready_o, 1);
    end
    @(negedge clk_i);
    s_trspvalid_i = 1'b1; m0_trspready_i = 1'b1; s_trspdata_i = 32'hcafe0001;
    #2 chk("full_rdy0", m0_treqready_o, 0);
    chk("full_sv", s_treqvalid_o, 0);
    chk("full_rv0", m0_trspvalid_o, 1);
    @(negedge clk_i);
    s_trspvalid_i = 1'b0;
    #2 chk("after_pop_rdy0", m0_treqready_o, 1);
    @(negedge clk_i);
    #2 chk("full2_rdy0", m0_treqready_o, 0);
    @(negedge clk_i);
    m0_treqdvalid_i = 1'b1; m0_treqaddr_i = 32'h80000000;
    #2 chk("full_wr_rdy0", m0_treqready_o, 1);
    chk("full_wr_addr", s_treqaddr_o, 32'h80000000);
    @(negedge clk_i);
    idle();
    s_trspvalid_i = 1'b1; m0_trspready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("drain%0d_rv0", i), m0_trspvalid_o, 1);
      @(negedge clk_i);
    end
    #2 chk("drained_rv0", m0_trspvalid_o, 0);
    chk("drained_err", err_o, 0);
    // arbitration with both masters reading back to back
`ifdef SSRAM_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      idle();
      m0_treqvalid_i = 1'b1; m0_treqaddr_i = 32'h1000 + 32'(4 * i);
      m1_treqvalid_i = 1'b1; m1_treqaddr_i = 32'h2000 + 32'(4 * i);
      s_treqready_i = 1'b1;
      #2 chk($sformatf("arb%0d_rdy0", i), m0_treqready_o, !exp_id[i]);
      chk($sformatf("arb%0d_rdy1", i), m1_treqready_o, exp_id[i]);
      chk($sformatf("arb%0d_addr", i), s_treqaddr_o, exp_id[i] ? 32'h2000 + 32'(4 * i) : 32'h1000 + 32'(4 * i));
    end
    @(negedge clk_i);
    idle();
    s_trspvalid_i = 1'b1; m0_trspready_i = 1'b1; m1_trspready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("arbrsp%0d_rv0", i), m0_trspvalid_o, !exp_id[i]);
      chk($sformatf("arbrsp%0d_rv1", i), m1_trspvalid_o, exp_id[i]);
      @(negedge clk_i);
    end
    // reset with a read outstanding discards its tracking entry
    idle();
    m0_treqvalid_i = 1'b1; s_treqready_i = 1'b1;
    #2 chk("mid_rdy0", m0_treqready_o, 1);
    do_reset();
    @(negedge clk_i);
    s_trspvalid_i = 1'b1; m0_trspready_i = 1'b1;
    #2 chk("mid_rv0", m0_trspvalid_o, 0);
    chk("mid_err_before", err_o, 0);
    @(negedge clk_i);
    s_trspvalid_i = 1'b0;
    #2 chk("mid_err_after", err_o, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssram_arb.md
SSRAM_ARB -- requirements
Module: ssram_arb

Interface
REQ-001 Parameter C_FIFO_DEPTHX, default 2, log2 of outstanding-read tracking depth (depth 4).
REQ-002 clk_i  input  1  system clock; all state on rising edge.
REQ-003 resetb_i  input  1  asynchronous, active-low reset.
REQ-004 clk_en_i  input  1  clock enable; state advances and transfers occur only when high.
REQ-005 m0_treqready_o  output  1  port 0 (instruction fetch) request accepted.
REQ-006 m0_treqvalid_i, m0_treqdvalid_i  input  1 each  port 0 request valid, write-data valid (1=write, 0=read).
REQ-007 m0_treqaddr_i, m0_treqdata_i  input  32 each  port 0 address, write data.
REQ-008 m0_trspready_i  input  1; m0_trspvalid_o  output  1; m0_trspdata_o  output  32  port 0 response channel.
REQ-009 m1_* (REQ-005..008 set)  port 1 (load/store), identical widths and directions.
REQ-010 s_treqready_i  input  1; s_treqvalid_o, s_treqdvalid_o  output  1; s_treqaddr_o, s_treqdata_o  output  32  request to the SSRAM target.
REQ-011 s_trspready_o  output  1; s_trspvalid_i  input  1; s_trspdata_i  input  32  response from target.
REQ-012 err_o  output  1  sticky: response received with no read outstanding.

Function
REQ-013 Port n eligible = mN_treqvalid_i & (mN_treqdvalid_i | tracking FIFO not full); a pop in the same cycle does not relieve full.
REQ-014 Grant combinational, at most one port per cycle; s_treqvalid_o = any port eligible.
REQ-015 s_treqdvalid_o/addr/data = granted port's signals; all zero when no port eligible.
REQ-016 mN_treqready_o = grant_n & s_treqready_i & clk_en_i; transfer occurs when it is high.
REQ-017 Single eligible port always granted; both eligible resolved per REQ-028/029.
REQ-018 Accepted read pushes granted port ID (1 bit) to tracking FIFO; accepted write pushes nothing and expects no response.
REQ-019 Response routed to FIFO head ID: mN_trspvalid_o = s_trspvalid_i & FIFO non-empty & head==n; both mN_trspdata_o = s_trspdata_i.
REQ-020 s_trspready_o = head port's mN_trspready_i when FIFO non-empty, else 1.
REQ-021 FIFO pops when s_trspvalid_i & s_trspready_o & non-empty & clk_en_i; push and pop same cycle keep occupancy unchanged.
REQ-022 Pointers wrap modulo 2**C_FIFO_DEPTHX; occupancy counter C_FIFO_DEPTHX+1 bits distinguishes full/empty.
REQ-023 s_trspvalid_i high with FIFO empty: response dropped, err_o set, held until reset.
REQ-024 Response order is request order; zero added latency on request and response paths.

Reset
REQ-025 resetb_i low asynchronously: FIFO empty, pointers 0, err_o 0, round-robin last-grant = port 1 (port 0 favoured first).
REQ-026 Reset mid-transaction discards all outstanding read tracking; later target responses raise err_o.
REQ-027 Combinational outputs in reset follow REQ-015/019/020 with empty FIFO.

Configuration
REQ-028 SSRAM_ARB_RR_EN defined: both eligible -> grant port other than last granted; last-grant updates on each transfer.
REQ-029 SSRAM_ARB_RR_EN undefined: both eligible -> port 0 always wins; no last-grant register.

Structure
REQ-030 Shared package ssram_pkg: port-ID width, C_FIFO_DEPTHX default, SSRAM_IDLE_DATA constant 32'hbaadf00d.
REQ-031 Tracking FIFO is sub-module ssram_arb_tagfifo (push, pop, full, empty, head).

Verification
REQ-032 Port 0 read 0x100, target returns 0x11223344 next cycle -> m0_trspvalid_o=1 data 0x11223344, m1_trspvalid_o=0.
REQ-033 Both ports read continuously, RR_EN defined -> grants alternate 0,1,0,1; responses routed in same order.
REQ-034 Both ports read, RR_EN undefined -> port 0 granted every cycle, m1_treqready_o stays 0.
REQ-035 Five reads, target response held off (trspvalid 0) -> four accepted, fifth m*_treqready_o=0; write to 0x80000000 still accepted.
REQ-036 m0_trspready_i=0 with port-0 response pending -> s_trspready_o=0, FIFO not popped, response delivered when ready rises.
REQ-037 s_trspvalid_i=1 with nothing outstanding -> err_o=1 next cycle, held; resetb_i low -> err_o=0.
